// File: rtl/ate_param.sv
// ate_param: block-wise adaptive threshold engine that emits one binarised bit per pixel, one block late.
// Optional macro ATE_OFFSET_EN adds a signed thr_offset input that is applied to the midpoint.
module ate_param #(
  parameter int PIX_W    = 8,
  parameter int BLK_LOG2 = 6,
  parameter int BLK_COLS = 6,
  parameter int BLK_ROWS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pix_valid,
  input  logic [PIX_W-1:0]        pix_data,
`ifdef ATE_OFFSET_EN
  input  logic signed [PIX_W-1:0] thr_offset,
`endif
  output logic                    bin_valid,
  output logic                    bin,
  output logic [PIX_W-1:0]        threshold,
  output logic                    frame_done
);
  localparam int BLK_PIX = 2 ** BLK_LOG2;
  localparam int COL_W   = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
  localparam int ROW_W   = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
  localparam logic [BLK_LOG2-1:0] LAST_PIX = BLK_LOG2'(BLK_PIX - 1);
  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(BLK_COLS - 1);
  localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(BLK_ROWS - 1);

  logic [BLK_LOG2-1:0] pix_cnt;
  logic [COL_W-1:0]    blk_col;
  logic [ROW_W-1:0]    blk_row;
  logic [PIX_W-1:0]    min_val;
  logic [PIX_W-1:0]    max_val;
  logic [PIX_W-1:0]    buffer [BLK_PIX];
  logic                prev_edge;
  logic                blk_seen;
  logic [PIX_W-1:0]    thr;

  logic                is_edge;
  logic                pix_last;
  logic                col_last;
  logic                row_last;
  logic [PIX_W-1:0]    store_val;
  logic [PIX_W-1:0]    old_pix;
  logic [PIX_W:0]      mid;
  logic [PIX_W-1:0]    mid_thr;
  logic [PIX_W-1:0]    thr_now;
`ifdef ATE_OFFSET_EN
  logic signed [PIX_W+1:0] offset_sum;
`endif

  // At pix_cnt==0 the threshold comes straight from the finished block's min/max; otherwise from the register.
  always_comb begin
    is_edge   = (blk_col == '0) || (blk_col == LAST_COL);
    pix_last  = (pix_cnt == LAST_PIX);
    col_last  = (blk_col == LAST_COL);
    row_last  = (blk_row == LAST_ROW);
    store_val = is_edge ? '0 : pix_data;
    old_pix   = buffer[pix_cnt];
    mid       = ({1'b0, min_val} + {1'b0, max_val} + (PIX_W + 1)'(1)) >> 1;
`ifdef ATE_OFFSET_EN
    offset_sum = $signed({1'b0, mid}) + $signed({{2{thr_offset[PIX_W-1]}}, thr_offset});
    if (offset_sum[PIX_W+1] || (offset_sum == '0)) begin
      mid_thr = PIX_W'(1);
    end else if (offset_sum[PIX_W]) begin
      mid_thr = '1;
    end else begin
      mid_thr = offset_sum[PIX_W-1:0];
    end
    if (prev_edge || !blk_seen) begin
      mid_thr = '0;
    end
`else
    mid_thr = (prev_edge || !blk_seen) ? '0 : PIX_W'(mid);
`endif
    thr_now = (pix_cnt == '0) ? mid_thr : thr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt    <= '0;
      blk_col    <= '0;
      blk_row    <= '0;
      min_val    <= '0;
      max_val    <= '0;
      prev_edge  <= 1'b0;
      blk_seen   <= 1'b0;
      thr        <= '0;
      bin        <= 1'b0;
      bin_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < BLK_PIX; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      bin_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        buffer[pix_cnt] <= store_val;
        bin             <= (thr_now != '0) && (old_pix >= thr_now);
        bin_valid       <= blk_seen;
        prev_edge       <= is_edge;
        if (pix_cnt == '0) begin
          thr <= thr_now;
        end
        if (is_edge) begin
          min_val <= '0;
          max_val <= '0;
        end else if (pix_cnt == '0) begin
          min_val <= pix_data;
          max_val <= pix_data;
        end else begin
          if (pix_data < min_val) min_val <= pix_data;
          if (pix_data > max_val) max_val <= pix_data;
        end
        // Block size is a power of two, so pix_cnt wraps on its own.
        pix_cnt <= pix_cnt + 1'b1;
        if (pix_last) begin
          blk_seen <= 1'b1;
          if (col_last) begin
            blk_col <= '0;
            if (row_last) begin
              blk_row    <= '0;
              frame_done <= 1'b1;
            end else begin
              blk_row <= blk_row + 1'b1;
            end
          end else begin
            blk_col <= blk_col + 1'b1;
          end
        end
      end
    end
  end

  assign threshold = thr;

endmodule

// File: tb/tb_ate_param.sv
// tb_ate_param: table-driven check of ate_param row 0, then hand-written frame-wrap and mid-block reset sequences.
module tb_ate_param;
  logic       clk;
  logic       reset;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       bin_valid;
  logic       bin;
  logic [7:0] threshold;
  logic       frame_done;

  ate_param dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .bin_valid  (bin_valid),
    .bin        (bin),
    .threshold  (threshold),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_valid;
    logic       exp_bin;
    logic [7:0] exp_thr;
  } vec_t;

  vec_t vecs [448];
  int   n_vec;
  int   total;
  int   passed;

  task automatic add_vec(input logic v, input logic [7:0] d, input logic ev, input logic eb,
                         input logic [7:0] et);
    vecs[n_vec].valid     = v;
    vecs[n_vec].data      = d;
    vecs[n_vec].exp_valid = ev;
    vecs[n_vec].exp_bin   = eb;
    vecs[n_vec].exp_thr   = et;
    n_vec++;
  endtask

  task automatic check_output(input string name, input int idx, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [7:0] d);
    pix_valid = v;
    pix_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    n_vec     = 0;
    reset     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;

    // Block (0,0) edge with arbitrary data; nothing is emitted yet.
    for (int i = 0; i < 64; i++) add_vec(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 8'd0);
    // Block (0,1) ramp 10..73 while block (0,0) comes out as threshold 0.
    for (int i = 0; i < 64; i++) add_vec(1'b1, 8'(10 + i), 1'b1, 1'b0, 8'd0);
    // Block (0,2) alternating 0/255 while the ramp comes out against threshold 42.
    for (int i = 0; i < 64; i++)
      add_vec(1'b1, (i % 2) ? 8'd255 : 8'd0, 1'b1, (10 + i) >= 42, 8'd42);
    // Block (0,3) ramp with valid toggling; the alternating block comes out against 128.
    for (int i = 0; i < 64; i++) begin
      add_vec(1'b1, 8'(10 + i), 1'b1, 1'((i % 2) == 1), 8'd128);
      add_vec(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'((i % 2) == 1), 8'd128);
    end
    // Block (0,4) all zeros, toggled; the toggled ramp must match the continuous case.
    for (int i = 0; i < 64; i++) begin
      add_vec(1'b1, 8'd0, 1'b1, (10 + i) >= 42, 8'd42);
      add_vec(1'b0, 8'($urandom_range(0, 255)), 1'b0, (10 + i) >= 42, 8'd42);
    end

    #12;
    check_output("rst_bin_valid", 0, 32'(bin_valid), 32'd0);
    check_output("rst_bin", 0, 32'(bin), 32'd0);
    check_output("rst_threshold", 0, 32'(threshold), 32'd0);
    check_output("rst_frame_done", 0, 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < n_vec; k++) begin
      apply_stimulus(vecs[k].valid, vecs[k].data);
      check_output("vec_bin_valid", k, 32'(bin_valid), 32'(vecs[k].exp_valid));
      check_output("vec_bin", k, 32'(bin), 32'(vecs[k].exp_bin));
      check_output("vec_threshold", k, 32'(threshold), 32'(vecs[k].exp_thr));
      check_output("vec_frame_done", k, 32'(frame_done), 32'd0);
    end

    // Block (0,5): the all-zero block hits the zero-threshold rule.
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b1, 8'(i));
      check_output("zero_blk_bin", i, 32'(bin), 32'd0);
      check_output("zero_blk_thr", i, 32'(threshold), 32'd0);
      check_output("zero_blk_valid", i, 32'(bin_valid), 32'd1);
    end

    // Rows 1..3; block (3,4) is all 255 and is emitted during (3,5).
    for (int r = 1; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        for (int i = 0; i < 64; i++) begin
          if (c == 0 || c == 5) apply_stimulus(1'b1, 8'($urandom_range(0, 255)));
          else if (r == 3 && c == 4) apply_stimulus(1'b1, 8'd255);
          else apply_stimulus(1'b1, 8'(10 + i));
          check_output("frame_done", r * 384 + c * 64 + i, 32'(frame_done),
                       32'(r == 3 && c == 5 && i == 63));
          if (r == 3 && c == 5) begin
            check_output("max_blk_thr", i, 32'(threshold), 32'd255);
            check_output("max_blk_bin", i, 32'(bin), 32'd1);
          end
        end
      end
    end

    // Next frame block (0,0): last block of the previous frame comes out as 0.
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b1, 8'd99);
      check_output("wrap_thr", 1536 + i, 32'(threshold), 32'd0);
      check_output("wrap_bin", 1536 + i, 32'(bin), 32'd0);
      check_output("wrap_valid", 1536 + i, 32'(bin_valid), 32'd1);
      check_output("wrap_frame_done", 1536 + i, 32'(frame_done), 32'd0);
    end
    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 8'(10 + i));
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b1, (i % 2) ? 8'd255 : 8'd0);
      check_output("restart_thr", i, 32'(threshold), 32'd42);
      check_output("restart_bin", i, 32'(bin), 32'((10 + i) >= 42));
    end
    for (int i = 0; i < 30; i++) apply_stimulus(1'b1, 8'(10 + i));
    check_output("pre_reset_valid", 0, 32'(bin_valid), 32'd1);
    check_output("pre_reset_thr", 0, 32'(threshold), 32'd128);

    // Asynchronous reset in the middle of block (0,3).
    #2;
    reset = 1'b0;
    #1;
    check_output("async_bin_valid", 0, 32'(bin_valid), 32'd0);
    check_output("async_bin", 0, 32'(bin), 32'd0);
    check_output("async_threshold", 0, 32'(threshold), 32'd0);
    check_output("async_frame_done", 0, 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b1, 8'(10 + i));
      check_output("post_reset_valid", i, 32'(bin_valid), 32'd0);
    end
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b1, 8'(10 + i));
      check_output("post_reset_edge_thr", i, 32'(threshold), 32'd0);
      check_output("post_reset_edge_bin", i, 32'(bin), 32'd0);
      check_output("post_reset_edge_valid", i, 32'(bin_valid), 32'd1);
    end
    for (int i = 0; i < 64; i++) begin
      apply_stimulus(1'b1, 8'd0);
      check_output("post_reset_thr", i, 32'(threshold), 32'd42);
      check_output("post_reset_bin", i, 32'(bin), 32'((10 + i) >= 42));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
